ccr_unit: RTL and testbench

Condition-code register for the execute stage. Latches the `{carry, negative, zero}` flags produced each cycle by the ALU into the architectural CCR, with a per-instruction flag write mask. Evaluates conditional jumps (JZ/JN/JC) against the registered flags and clears the tested flag when a jump is taken. Saves and restores the CCR on interrupt entry and RTI through a small hardware stack.

---
 rtl/ccr_unit_pkg.sv | 29 ++
 rtl/ccr_stack.sv | 102 ++++++++++
 rtl/ccr_unit.sv | 92 +++++++++
 tb/tb_ccr_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ccr_unit_pkg.sv
// Shared types and constants for the condition-code register slice.
package ccr_unit_pkg;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  typedef logic [2:0] ccr_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JZ   = 2'b01,
    JMP_JN   = 2'b10,
    JMP_JC   = 2'b11
  } jmp_t;

  // One-hot select of the flag a conditional jump tests (all zero for JMP_NONE).
  function automatic ccr_t jmp_sel(input jmp_t t);
    ccr_t sel;
    case (t)
      JMP_JZ:  sel = ccr_t'(3'b001 << CCR_Z);
      JMP_JN:  sel = ccr_t'(3'b001 << CCR_N);
      JMP_JC:  sel = ccr_t'(3'b001 << CCR_C);
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ccr_stack.sv
// Small LIFO holding saved CCR values across interrupt nesting.
module ccr_stack
  import ccr_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  ccr_t          din,
  output ccr_t          top,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          unf
);

  localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ccr_t          mem_r [DEPTH];
  logic [CW-1:0] cnt_r;
  logic          ovf_r;
  logic          unf_r;
  logic          empty_s;
  logic          full_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;
  logic [IW-1:0] mem_idx_s;
  logic          mem_we_s;

  // Occupancy decode, top read and the single memory write port select.
  always_comb begin
    empty_s  = (cnt_r == CW'(0));
    full_s   = (cnt_r == FULL);
    wr_idx_s = IW'(cnt_r);
    rd_idx_s = IW'(cnt_r - CW'(1));
    if (empty_s) begin
      top = 3'b000;
    end else begin
      top = mem_r[rd_idx_s];
    end
    // A swap overwrites the current top in place; a plain push writes above it.
    if (push && !pop && !full_s) begin
      mem_we_s  = 1'b1;
      mem_idx_s = wr_idx_s;
    end else if (push && pop && !empty_s) begin
      mem_we_s  = 1'b1;
      mem_idx_s = rd_idx_s;
    end else begin
      mem_we_s  = 1'b0;
      mem_idx_s = rd_idx_s;
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= din;
    end
  end

  // Occupancy counter with saturation and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (full_s) begin
            ovf_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        2'b01: begin
          if (empty_s) begin
            unf_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        2'b11: begin
          if (empty_s) begin
            unf_r <= 1'b1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign cnt = cnt_r;
  assign ovf = ovf_r;
  assign unf = unf_r;

endmodule

// File: rtl/ccr_unit.sv
// Execute-stage condition-code register: masked flag writes, conditional
// jump evaluation with flag clear, and interrupt save/restore.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   ccr_in,
  input  logic                         ccr_we,
  input  logic [2:0]                   ccr_mask,
  input  logic                         jmp_valid,
  input  logic [1:0]                   jmp_type,
  input  logic                         int_save,
  input  logic                         rti_restore,
  input  logic                         stall,
  input  logic                         flush,
  output logic [2:0]                   ccr,
  output logic                         jmp_taken,
  output logic [$clog2(DEPTH+1)-1:0]   stk_cnt,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  localparam int CW = $clog2(DEPTH + 1);

  ccr_t ccr_r;
  ccr_t upd_s;
  ccr_t sel_s;
  ccr_t top_s;
  logic kill_s;
  logic we_s;
  logic jv_s;
  logic taken_s;
  logic push_s;
  logic pop_s;

  // Kill gating, jump decision on the registered flags, and next-flag value.
  always_comb begin
    kill_s  = stall | flush;
    we_s    = ccr_we & ~kill_s;
    jv_s    = jmp_valid & ~kill_s;
    sel_s   = jmp_sel(jmp_t'(jmp_type));
    taken_s = jv_s & (|(ccr_r & sel_s));
    if (we_s) begin
      upd_s = (ccr_r & ~ccr_mask) | (ccr_in & ccr_mask);
    end else begin
      upd_s = ccr_r;
    end
    // Clearing the tested flag wins over a same-cycle write of that flag.
    if (taken_s) begin
      upd_s = upd_s & ~sel_s;
    end else begin
      upd_s = upd_s;
    end
    push_s = int_save & ~stall;
    pop_s  = rti_restore & ~stall;
  end

  // Architectural flags; a pop (alone or in a swap) takes the stack top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_r <= 3'b000;
    end else if (stall) begin
      ccr_r <= ccr_r;
    end else if (pop_s) begin
      ccr_r <= top_s;
    end else begin
      ccr_r <= upd_s;
    end
  end

  ccr_stack #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (upd_s),
    .top   (top_s),
    .cnt   (stk_cnt),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

  assign ccr       = ccr_r;
  assign jmp_taken = taken_s;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: directed scenarios plus random traffic
// checked against a queue-based flag/stack model.
module tb_ccr_unit;
  import ccr_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    ccr_in;
  logic          ccr_we;
  logic [2:0]    ccr_mask;
  logic          jmp_valid;
  logic [1:0]    jmp_type;
  logic          int_save;
  logic          rti_restore;
  logic          stall;
  logic          flush;
  logic [2:0]    ccr;
  logic          jmp_taken;
  logic [CW-1:0] stk_cnt;
  logic          stk_ovf;
  logic          stk_unf;

  ccr_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ccr_in      (ccr_in),
    .ccr_we      (ccr_we),
    .ccr_mask    (ccr_mask),
    .jmp_valid   (jmp_valid),
    .jmp_type    (jmp_type),
    .int_save    (int_save),
    .rti_restore (rti_restore),
    .stall       (stall),
    .flush       (flush),
    .ccr         (ccr),
    .jmp_taken   (jmp_taken),
    .stk_cnt     (stk_cnt),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          taken;
    logic [2:0]    ccr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [2:0] m_ccr;
  logic [2:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one EX-stage cycle and queue what the reference model predicts.
  task automatic step(input logic [2:0] cin, input logic we_i, input logic [2:0] mk,
                      input logic jv_i, input logic [1:0] ty, input logic sv,
                      input logic rs, input logic st, input logic fl);
    logic       we;
    logic       jv;
    logic       taken;
    logic [2:0] upd;
    int         k;
    exp_t       e;
    @(negedge clk);
    ccr_in = cin; ccr_we = we_i; ccr_mask = mk; jmp_valid = jv_i; jmp_type = ty;
    int_save = sv; rti_restore = rs; stall = st; flush = fl;
    we    = we_i && !(st || fl);
    jv    = jv_i && !(st || fl);
    k     = int'(ty) - 1;
    taken = jv && (ty != 2'd0) && m_ccr[k];
    for (int i = 0; i < 3; i++) begin
      upd[i] = (we && mk[i]) ? cin[i] : m_ccr[i];
    end
    if (taken) upd[k] = 1'b0;
    if (!st) begin
      if (sv && !rs) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(upd);
        else m_ovf = 1'b1;
        m_ccr = upd;
      end else if (rs && !sv) begin
        if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
        else begin m_ccr = 3'b000; m_unf = 1'b1; end
      end else if (rs && sv) begin
        if (m_stk.size() > 0) begin m_ccr = m_stk[$]; m_stk[$] = upd; end
        else begin m_ccr = 3'b000; m_unf = 1'b1; end
      end else begin
        m_ccr = upd;
      end
    end
    e.taken = taken;
    e.ccr   = m_ccr;
    e.cnt   = CW'(m_stk.size());
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    #1;
    sb_q.push_back(e);
  endtask

  // Monitor: jump decision mid-cycle, registered state just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("jmp_taken", 8'(jmp_taken), 8'(e.taken));
        @(posedge clk);
        #1;
        chk("ccr", 8'(ccr), 8'(e.ccr));
        chk("stk_cnt", 8'(stk_cnt), 8'(e.cnt));
        chk("stk_ovf", 8'(stk_ovf), 8'(e.ovf));
        chk("stk_unf", 8'(stk_unf), 8'(e.unf));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : driver
    rst_n = 1'b0;
    ccr_in = 3'b000; ccr_we = 1'b0; ccr_mask = 3'b000; jmp_valid = 1'b0; jmp_type = 2'b00;
    int_save = 1'b0; rti_restore = 1'b0; stall = 1'b0; flush = 1'b0;
    m_ccr = 3'b000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    chk("reset_ccr", 8'(ccr), 8'h0);
    chk("reset_cnt", 8'(stk_cnt), 8'h0);
    chk("reset_ovf", 8'(stk_ovf), 8'h0);
    chk("reset_unf", 8'(stk_unf), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // masked update
    step(3'b101, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b1, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    // JZ taken, then JZ racing a same-cycle Z write
    step(3'b001, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b1, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    // stall holds everything; flush still lets a push through
    step(3'b100, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b011, 1'b1, 3'b111, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(3'b011, 1'b1, 3'b111, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    // nested interrupts, overflow and underflow
    step(3'b110, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    // swap top with the post-instruction flags
    step(3'b011, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'b100, 1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // drain the stack, leave ccr=111 with one saved entry, then reset mid-cycle
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(3'b111, 1'b1, 3'b111, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_ccr", 8'(ccr), 8'h0);
    chk("async_cnt", 8'(stk_cnt), 8'h0);
    chk("async_ovf", 8'(stk_ovf), 8'h0);
    chk("async_unf", 8'(stk_unf), 8'h0);
    chk("async_taken", 8'(jmp_taken), 8'h0);
    chk("queue_drained", 8'(sb_q.size()), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
